// File: rtl/tlc_timing_pkg.sv
// Shared timing definitions for the traffic-light controller: countdown state
// encoding, default interval durations and well-known interval indices.
package tlc_timing_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cd_state_e;

    // Well-known interval indices used by the light controller.
    localparam int T_BLUE   = 0;
    localparam int T_EMERG  = 1;
    localparam int T_YELLOW = 2;

    localparam int MAX_INTERVALS = 16;

    // Reset durations in ticks; entry i sits at bits [i*4 +: 4].
    localparam logic [15:0] DEF_DURATIONS = {4'd1, 4'd2, 4'd3, 4'd6};

    // Bit i is set when index i names an implemented interval.
    function automatic logic [MAX_INTERVALS-1:0] index_mask(input int num_intervals);
        logic [MAX_INTERVALS-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_INTERVALS; i++) begin
            if (i < num_intervals) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/itb_countdown.sv
// Countdown engine for the interval timer bank: loads a duration on a strobe,
// decrements it on each tick and pulses 'expired' when it runs out.
module itb_countdown
    import tlc_timing_pkg::*;
#(
    parameter int VAL_W = 4
) (
    input  logic             clk,
    input  logic             reset_sync,
    input  logic             tick,
    input  logic             load,
    input  logic [VAL_W-1:0] load_val,
    output logic [VAL_W-1:0] remaining,
    output logic             busy,
    output logic             expired
);

    cd_state_e        state_q, state_d;
    logic [VAL_W-1:0] remaining_q, remaining_d;
    logic             expired_q, expired_d;

    // Next-state logic: a load always wins over a same-cycle tick, so a
    // restart never produces an expiry pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        remaining_d = remaining_q;
        expired_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    remaining_d = load_val;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load) begin
                    remaining_d = load_val;
                end else if (tick) begin
                    if (remaining_q > VAL_W'(1)) begin
                        remaining_d = remaining_q - VAL_W'(1);
                    end else begin
                        remaining_d = '0;
                        expired_d   = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any countdown without an expiry pulse.
    always_ff @(posedge clk or posedge reset_sync) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its inputs from before the edge, independent of statement order.
        if (reset_sync) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
        end
    end

    assign remaining = remaining_q;
    assign busy      = (state_q == ST_RUN);
    assign expired   = expired_q;

endmodule

// File: rtl/interval_timer_bank.sv
// Interval timer bank: a table of runtime-programmable durations, a registered
// lookup of the interval selected by the light controller, and a countdown of
// that interval on the 1 Hz tick.
module interval_timer_bank
    import tlc_timing_pkg::*;
#(
    parameter int                             NUM_INTERVALS = 4,
    parameter int                             VAL_W         = 4,
    parameter logic [NUM_INTERVALS*VAL_W-1:0] DEFAULT_VALS  = DEF_DURATIONS,
    localparam int                            SEL_W         = $clog2(NUM_INTERVALS)
) (
    input  logic             clk,
    input  logic             reset_sync,
    input  logic             tick,
    input  logic             prog_sync,
    input  logic [SEL_W-1:0] tp_sel,
    input  logic [VAL_W-1:0] t_val,
    input  logic [SEL_W-1:0] interval,
    input  logic             start,
    output logic [VAL_W-1:0] tp_val,
    output logic [VAL_W-1:0] remaining,
    output logic             busy,
    output logic             expired,
    output logic             err
);

    localparam logic [MAX_INTERVALS-1:0] IDX_MASK = index_mask(NUM_INTERVALS);

    logic [VAL_W-1:0] table_q [NUM_INTERVALS];
    logic [VAL_W-1:0] tp_val_q;
    logic             err_q;

    logic             interval_ok;
    logic             prog_ok;
    logic             load;
    logic [VAL_W-1:0] sel_val;

    // Index checks: a write needs an implemented index and a non-zero
    // duration, so the table never holds a zero duration.
    assign interval_ok = IDX_MASK[interval];
    assign prog_ok     = IDX_MASK[tp_sel] && (t_val != '0);
    assign load        = start && interval_ok;

    // Table read for the requested interval; this is the pre-write value
    // when a program lands on the same index in the same cycle.
    always_comb begin
        sel_val = '0;
        if (interval_ok) sel_val = table_q[interval];
    end

    // Duration table: accepted program writes only.
    always_ff @(posedge clk or posedge reset_sync) begin
        // NOTE: the table is a handful of flops that must come up holding the
        // default durations, so it is reset like any other register.
        if (reset_sync) begin
            for (int i = 0; i < NUM_INTERVALS; i++) begin
                table_q[i] <= DEFAULT_VALS[i*VAL_W +: VAL_W];
            end
        end else if (prog_sync && prog_ok) begin
            table_q[tp_sel] <= t_val;
        end
    end

    // Registered lookup and error pulse; an out-of-range lookup holds tp_val.
    always_ff @(posedge clk or posedge reset_sync) begin
        if (reset_sync) begin
            tp_val_q <= DEFAULT_VALS[VAL_W-1:0];
            err_q    <= 1'b0;
        end else begin
            if (interval_ok) tp_val_q <= sel_val;
            err_q <= (prog_sync && !prog_ok) || (start && !interval_ok);
        end
    end

    itb_countdown #(
        .VAL_W (VAL_W)
    ) u_countdown (
        .clk        (clk),
        .reset_sync (reset_sync),
        .tick       (tick),
        .load       (load),
        .load_val   (sel_val),
        .remaining  (remaining),
        .busy       (busy),
        .expired    (expired)
    );

    assign tp_val = tp_val_q;
    assign err    = err_q;

endmodule

// File: tb/tb_interval_timer_bank.sv
// Self-checking bench for interval_timer_bank: a 4-interval and a 3-interval
// instance share one stimulus stream and are compared each cycle against a
// behavioural model, plus directed checks of the documented scenarios.
module tb_interval_timer_bank;

    localparam int VAL_W = 4;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             reset_sync;
    logic             tick;
    logic             prog_sync;
    logic [SEL_W-1:0] tp_sel;
    logic [VAL_W-1:0] t_val;
    logic [SEL_W-1:0] interval;
    logic             start;

    logic [VAL_W-1:0] tp_val    [2];
    logic [VAL_W-1:0] remaining [2];
    logic             busy      [2];
    logic             expired   [2];
    logic             err       [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    interval_timer_bank u_dut4 (
        .clk        (clk),
        .reset_sync (reset_sync),
        .tick       (tick),
        .prog_sync  (prog_sync),
        .tp_sel     (tp_sel),
        .t_val      (t_val),
        .interval   (interval),
        .start      (start),
        .tp_val     (tp_val[0]),
        .remaining  (remaining[0]),
        .busy       (busy[0]),
        .expired    (expired[0]),
        .err        (err[0])
    );

    interval_timer_bank #(
        .NUM_INTERVALS (3),
        .VAL_W         (4),
        .DEFAULT_VALS  (12'h236)
    ) u_dut3 (
        .clk        (clk),
        .reset_sync (reset_sync),
        .tick       (tick),
        .prog_sync  (prog_sync),
        .tp_sel     (tp_sel),
        .t_val      (t_val),
        .interval   (interval),
        .start      (start),
        .tp_val     (tp_val[1]),
        .remaining  (remaining[1]),
        .busy       (busy[1]),
        .expired    (expired[1]),
        .err        (err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int n_of [2] = '{4, 3};
    int defs [4] = '{6, 3, 2, 1};
    int m_tab  [2][4];
    int m_tp   [2];
    int m_rem  [2];
    bit m_busy [2];
    bit m_exp  [2];
    bit m_err  [2];

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 4; i++) m_tab[u][i] = defs[i];
            m_tp[u]   = m_tab[u][0];
            m_rem[u]  = 0;
            m_busy[u] = 1'b0;
            m_exp[u]  = 1'b0;
            m_err[u]  = 1'b0;
        end
    endtask

    // One clock edge of the documented behaviour, using the inputs present
    // before the edge and the table contents from before any write.
    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            int  sel = int'(tp_sel);
            int  iv  = int'(interval);
            int  v   = int'(t_val);
            bit  iv_ok = (iv < n_of[u]);
            bit  wr_ok = (sel < n_of[u]) && (v != 0);
            m_err[u] = (prog_sync && !wr_ok) || (start && !iv_ok);
            m_exp[u] = 1'b0;
            if (start && iv_ok) begin
                m_rem[u]  = m_tab[u][iv];
                m_busy[u] = 1'b1;
            end else if (m_busy[u] && tick) begin
                m_rem[u] = m_rem[u] - 1;
                if (m_rem[u] == 0) begin
                    m_busy[u] = 1'b0;
                    m_exp[u]  = 1'b1;
                end
            end
            if (iv_ok) m_tp[u] = m_tab[u][iv];
            if (prog_sync && wr_ok) m_tab[u][sel] = v;
        end
    endtask

    task automatic compare_all(input string ctx);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s u%0d tp_val", ctx, u),    32'(tp_val[u]),    32'(m_tp[u]));
            check($sformatf("%s u%0d remaining", ctx, u), 32'(remaining[u]), 32'(m_rem[u]));
            check($sformatf("%s u%0d busy", ctx, u),      32'(busy[u]),      32'(m_busy[u]));
            check($sformatf("%s u%0d expired", ctx, u),   32'(expired[u]),   32'(m_exp[u]));
            check($sformatf("%s u%0d err", ctx, u),       32'(err[u]),       32'(m_err[u]));
        end
    endtask

    task automatic set_in(input bit p, input int sel, input int v, input int iv,
                          input bit st, input bit tk);
        prog_sync = p;
        tp_sel    = SEL_W'(sel);
        t_val     = VAL_W'(v);
        interval  = SEL_W'(iv);
        start     = st;
        tick      = tk;
    endtask

    // Advance one clock, update the model and compare away from the edge.
    task automatic step(input string ctx);
        @(posedge clk);
        model_step();
        #1;
        compare_all(ctx);
    endtask

    initial begin
        reset_sync = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset tp_val",    32'(tp_val[0]),    32'd6);
        check("reset remaining", 32'(remaining[0]), 32'd0);
        check("reset busy",      32'(busy[0]),      32'd0);
        check("reset expired",   32'(expired[0]),   32'd0);
        check("reset err",       32'(err[0]),       32'd0);
        compare_all("reset");
        reset_sync = 1'b0;

        // Lookup of the default table.
        set_in(0, 0, 0, 0, 0, 0); step("lookup");
        check("lookup idx0", 32'(tp_val[0]), 32'd6);
        set_in(0, 0, 0, 1, 0, 0); step("lookup");
        check("lookup idx1", 32'(tp_val[0]), 32'd3);
        set_in(0, 0, 0, 2, 0, 0); step("lookup");
        check("lookup idx2", 32'(tp_val[0]), 32'd2);

        // Program index 1 while looking it up: old value, then new value.
        set_in(1, 1, 9, 1, 0, 0); step("prog");
        check("rbw old value", 32'(tp_val[0]), 32'd3);
        set_in(0, 0, 0, 1, 0, 0); step("prog");
        check("rbw new value", 32'(tp_val[0]), 32'd9);

        // Zero duration is rejected.
        set_in(1, 1, 0, 1, 0, 0); step("prog zero");
        check("prog zero err", 32'(err[0]), 32'd1);
        set_in(0, 0, 0, 1, 0, 0); step("prog zero");
        check("prog zero err clears", 32'(err[0]), 32'd0);
        check("prog zero no write", 32'(tp_val[0]), 32'd9);

        // Countdown of interval 2 to expiry.
        set_in(0, 0, 0, 2, 1, 0); step("cd");
        check("cd load", 32'(remaining[0]), 32'd2);
        check("cd busy", 32'(busy[0]), 32'd1);
        set_in(0, 0, 0, 2, 0, 1); step("cd");
        check("cd tick1", 32'(remaining[0]), 32'd1);
        check("cd tick1 expired", 32'(expired[0]), 32'd0);
        step("cd");
        check("cd tick2", 32'(remaining[0]), 32'd0);
        check("cd expired pulse", 32'(expired[0]), 32'd1);
        check("cd busy low", 32'(busy[0]), 32'd0);
        set_in(0, 0, 0, 2, 0, 0); step("cd");
        check("cd expired one cycle", 32'(expired[0]), 32'd0);

        // Restart wins over a same-cycle tick.
        set_in(0, 0, 0, 0, 1, 0); step("restart");
        set_in(0, 0, 0, 0, 0, 1); step("restart"); step("restart");
        check("restart pre", 32'(remaining[0]), 32'd4);
        set_in(0, 0, 0, 0, 1, 1); step("restart");
        check("restart reload", 32'(remaining[0]), 32'd6);
        check("restart no expiry", 32'(expired[0]), 32'd0);

        // Programming the running interval affects only the next start.
        set_in(1, 0, 15, 0, 0, 0); step("prog run");
        check("prog run unaffected", 32'(remaining[0]), 32'd6);
        set_in(0, 0, 0, 0, 0, 1); step("prog run");
        check("prog run ticks", 32'(remaining[0]), 32'd5);
        set_in(0, 0, 0, 0, 1, 0); step("prog run");
        check("prog run next start", 32'(remaining[0]), 32'd15);

        // Out-of-range start on the 3-interval instance.
        set_in(0, 0, 0, 3, 1, 0); step("oor");
        check("oor err", 32'(err[1]), 32'd1);
        check("oor busy kept", 32'(busy[1]), 32'd1);
        check("oor remaining kept", 32'(remaining[1]), 32'd15);
        check("oor valid on 4", 32'(remaining[0]), 32'd1);

        // Reset mid-countdown, with a tick that would otherwise expire it.
        set_in(0, 0, 0, 3, 0, 1);
        #2;
        reset_sync = 1'b1;
        #1;
        model_reset();
        compare_all("midreset");
        check("midreset busy", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1;
        check("midreset no expiry", 32'(expired[0]), 32'd0);
        compare_all("midreset hold");
        reset_sync = 1'b0;

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            set_in($urandom_range(0, 7) == 0,
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)),
                   $urandom_range(0, 11) == 0,
                   $urandom_range(0, 2) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
